// File: rtl/fft_pkg.sv
// Shared constants, FSM state encoding and address helpers for the FFT sequencer.
package fft_pkg;

  localparam int unsigned N     = 64;
  localparam int unsigned LOG2N = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STAGE,
    ST_DRAIN,
    ST_DONE
  } fft_state_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LOG2N; i++) begin
      r[i] = v[LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_wb_delay.sv
// Write-back delay line: carries {valid, addr_a, addr_b} of each butterfly issue
// through the butterfly pipeline latency so write-back lines up with the result.
module fft_wb_delay #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned AW    = 6
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [AW-1:0] a_i,
  input  logic [AW-1:0] b_i,
  output logic          valid_o,
  output logic [AW-1:0] a_o,
  output logic [AW-1:0] b_o
);

  logic [DEPTH-1:0] v_q;
  logic [AW-1:0]    a_q [DEPTH];
  logic [AW-1:0]    b_q [DEPTH];

  // Bubbles carry zero addresses so an idle write port is fully quiet.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      v_q[0] <= push_i;
      a_q[0] <= push_i ? a_i : '0;
      b_q[0] <= push_i ? b_i : '0;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        v_q[i] <= v_q[i-1];
        a_q[i] <= a_q[i-1];
        b_q[i] <= b_q[i-1];
      end
    end
  end

  assign valid_o = v_q[DEPTH-1];
  assign a_o     = a_q[DEPTH-1];
  assign b_o     = b_q[DEPTH-1];

endmodule

// File: rtl/fft_sched.sv
// Radix-2 DIT FFT sequencer: bit-reversed load, per-stage butterfly address and
// twiddle generation, drain between stages, delayed write-back addresses.
module fft_sched #(
  parameter int unsigned N      = fft_pkg::N,
  parameter int unsigned LOG2N  = fft_pkg::LOG2N,
  parameter int unsigned BF_LAT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [LOG2N-1:0] ld_addr,
  output logic             ld_we,
  output logic             bf_valid,
  input  logic             bf_ready,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-1:0] tw_idx,
  output logic [2:0]       stage,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b
);

  import fft_pkg::*;

  localparam int unsigned DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

  fft_state_t       state_q, state_d;
  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic [LOG2N-1:0] j_q, j_d;
  logic [2:0]       s_q, s_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic [LOG2N-1:0] addr_a_q, addr_a_d;
  logic [LOG2N-1:0] addr_b_q, addr_b_d;
  logic [LOG2N-1:0] tw_q, tw_d;
  logic [LOG2N-1:0] h, pos;
  logic             bf_fire;
  logic             addr_ld;

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign in_ready = (state_q == ST_LOAD);
  assign ld_we    = in_valid && in_ready;
  assign ld_addr  = bitrev(cnt_q);
  assign bf_valid = (state_q == ST_STAGE);
  assign bf_fire  = bf_valid && bf_ready;
  assign addr_a   = addr_a_q;
  assign addr_b   = addr_b_q;
  assign tw_idx   = tw_q;
  assign stage    = s_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    j_d     = j_q;
    s_d     = s_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (ld_we) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LOG2N'(N-1)) begin
            state_d = ST_STAGE;
            s_d     = '0;
            j_d     = '0;
          end
        end
      end
      ST_STAGE: begin
        if (bf_fire) begin
          if (j_q == LOG2N'(N/2-1)) begin
            state_d = ST_DRAIN;
            j_d     = '0;
            dcnt_d  = '0;
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (dcnt_q == DW'(BF_LAT-1)) begin
          if (s_q == 3'(LOG2N-1)) begin
            state_d = ST_DONE;
            s_d     = '0;
          end else begin
            state_d = ST_STAGE;
            s_d     = s_q + 1'b1;
          end
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Addresses are computed from the next (s, j) and registered, so they are
  // valid in the first STAGE cycle and hold across bf_ready stalls.
  always_comb begin
    h        = LOG2N'(1) << s_d;
    pos      = j_d & (h - 1'b1);
    addr_a_d = ((j_d >> s_d) << (s_d + 3'd1)) | pos;
    addr_b_d = addr_a_d + h;
    tw_d     = pos << (3'(LOG2N-1) - s_d);
    addr_ld  = (state_d == ST_STAGE) && ((state_q != ST_STAGE) || bf_fire);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      j_q      <= '0;
      s_q      <= '0;
      dcnt_q   <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tw_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      s_q     <= s_d;
      dcnt_q  <= dcnt_d;
      if (addr_ld) begin
        addr_a_q <= addr_a_d;
        addr_b_q <= addr_b_d;
        tw_q     <= tw_d;
      end
    end
  end

  fft_wb_delay #(
    .DEPTH (BF_LAT),
    .AW    (LOG2N)
  ) u_wb_delay (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (bf_fire),
    .a_i     (addr_a_q),
    .b_i     (addr_b_q),
    .valid_o (wr_en),
    .a_o     (wr_addr_a),
    .b_o     (wr_addr_b)
  );

endmodule

// File: tb/tb_fft_sched.sv
// Directed bench for fft_sched: reset, load order, butterfly addressing, stalls,
// write-back alignment, done timing, abort and ignored start pulses.
module tb_fft_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy, done;
  logic       in_valid, in_ready;
  logic [5:0] ld_addr;
  logic       ld_we;
  logic       bf_valid, bf_ready;
  logic [5:0] addr_a, addr_b, tw_idx;
  logic [2:0] stage;
  logic       wr_en;
  logic [5:0] wr_addr_a, wr_addr_b;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  fft_sched #(
    .N      (64),
    .LOG2N  (6),
    .BF_LAT (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ld_addr   (ld_addr),
    .ld_we     (ld_we),
    .bf_valid  (bf_valid),
    .bf_ready  (bf_ready),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .tw_idx    (tw_idx),
    .stage     (stage),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({busy, done, in_ready, ld_addr, ld_we, bf_valid, addr_a, addr_b,
                tw_idx, stage, wr_en, wr_addr_a, wr_addr_b});
  endfunction

  // One transform from start to well past done; cycle 0 is the start cycle.
  task automatic run_xform(input bit stall, input bit pulse);
    int unsigned c, nld, s_e, j_e, nwr, ndone, done_cyc, nstall, addr_mis, wr_mis;
    int unsigned hh, ea, eb, etw;
    logic [12:0] wr_exp [0:511];
    for (int i = 0; i < 512; i++) wr_exp[i] = '0;
    c = 0; nld = 0; s_e = 0; j_e = 0; nwr = 0; ndone = 0; done_cyc = 0;
    nstall = 0; addr_mis = 0; wr_mis = 0;
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; bf_ready = 1'b1;
    while (c < 300) begin
      @(negedge clk);
      c++;
      start = pulse && (c == 10 || c == 100);
      if ({wr_en, wr_addr_a, wr_addr_b} !== wr_exp[c]) wr_mis++;
      if (wr_en) nwr++;
      if (done) begin
        ndone++;
        done_cyc = c;
      end
      if (ndone > 0 && c == done_cyc + 1) check("busy_fall", busy, 0);
      if (c == 64) check("load_last_ready", in_ready, 1);
      if (c == 65) check("stage_entry", {bf_valid, in_ready}, 2'b10);
      if (ld_we) begin
        if (nld == 1)  check("ld_addr_s1", ld_addr, 32);
        if (nld == 3)  check("ld_addr_s3", ld_addr, 48);
        if (nld == 63) check("ld_addr_s63", ld_addr, 63);
        nld++;
      end
      bf_ready = 1'b1;
      if (stall && bf_valid && s_e == 1 && j_e == 10 && nstall < 3) begin
        bf_ready = 1'b0;
        nstall++;
        check("stall_hold", {addr_a, addr_b, tw_idx, stage}, {6'd20, 6'd22, 6'd0, 3'd1});
      end
      if (bf_valid && bf_ready) begin
        hh  = 1 << s_e;
        ea  = (j_e / hh) * 2 * hh + (j_e % hh);
        eb  = ea + hh;
        etw = (j_e % hh) * (64 / (2 * hh));
        if (addr_a !== 6'(ea) || addr_b !== 6'(eb) || tw_idx !== 6'(etw) || stage !== 3'(s_e))
          addr_mis++;
        if (j_e == 0 && s_e > 0) check("prev_stage_written", nwr, 32 * s_e);
        if (s_e == 0 && j_e == 0) check("s0_j0", {addr_a, addr_b, tw_idx}, {6'd0, 6'd1, 6'd0});
        if (s_e == 0 && j_e == 1) check("s0_j1", {addr_a, addr_b, tw_idx}, {6'd2, 6'd3, 6'd0});
        if (s_e == 2 && j_e == 5) check("s2_j5", {addr_a, addr_b, tw_idx}, {6'd9, 6'd13, 6'd8});
        if (s_e == 5 && j_e == 31) check("s5_j31", {addr_a, addr_b, tw_idx}, {6'd31, 6'd63, 6'd31});
        wr_exp[c + 3] = {1'b1, 6'(ea), 6'(eb)};
        j_e++;
        if (j_e == 32) begin
          j_e = 0;
          s_e++;
        end
      end
    end
    check("done_cycle", done_cyc, stall ? 278 : 275);
    check("done_count", ndone, 1);
    check("wr_count", nwr, 192);
    check("issue_count", s_e, 6);
    check("addr_model", addr_mis, 0);
    check("wr_align", wr_mis, 0);
    check("idle_after", busy, 0);
    if (stall) check("stall_cycles", nstall, 3);
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b1;
    bf_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs", outs(), 0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    run_xform(1'b1, 1'b1);

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    check("abort_in_stage", bf_valid, 1);
    #2 reset = 1'b0;
    #1 check("abort_outs", outs(), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_idle", {busy, done}, 2'b00);

    run_xform(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
